// File: rtl/alu_pkg.sv
// Shared types for the execute-stage divide/remainder unit.
// Opcode encoding matches the 2-bit divOpcode field driven by the decoder.
package alu_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        DIV_OP  = 2'b00,
        DIVU_OP = 2'b01,
        REM_OP  = 2'b10,
        REMU_OP = 2'b11
    } div_op_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } div_state_t;

endpackage

// File: rtl/alu_divider_if.sv
// Request/result bundle between the execute stage and the divider.
// The master side issues operands and start; the slave side returns busy/done/result.
interface alu_divider_if
    import alu_pkg::*;
#(
    parameter int WIDTH = XLEN
);

    logic             start_in;
    logic [1:0]       divOpcode_in;
    logic [WIDTH-1:0] operand1_in;
    logic [WIDTH-1:0] operand2_in;
    logic             busy_out;
    logic             done_out;
    logic [WIDTH-1:0] result_out;
    logic             zeroFlag_out;

    modport master (
        output start_in, divOpcode_in, operand1_in, operand2_in,
        input  busy_out, done_out, result_out, zeroFlag_out
    );

    modport slave (
        input  start_in, divOpcode_in, operand1_in, operand2_in,
        output busy_out, done_out, result_out, zeroFlag_out
    );

endinterface

// File: rtl/alu_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, then
// subtract the divisor when it fits and emit the matching quotient bit.
module alu_div_step
    import alu_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {rem, dvd_bit};
    assign diff    = shifted - {1'b0, divisor};

    // rem < divisor on entry, so a clear borrow bit means shifted >= divisor
    assign q_bit    = ~diff[WIDTH];
    assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/alu_divider.sv
// Iterative DIV/DIVU/REM/REMU unit with start/busy/done handshake.
// Optional macro ALU_DIVIDER_EARLY_OUT_EN skips CALC when |op1| < |op2|.
module alu_divider
    import alu_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input logic       clk_in,
    input logic       reset_in,
    alu_divider_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state;
    div_op_t          op;
    div_op_t          op_in;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] result;
    logic             q_sign;
    logic             r_sign;
    logic [CNT_W-1:0] count;

    logic             accept;
    logic             is_signed;
    logic             sign1;
    logic             sign2;
    logic             div_by_zero;
    logic             overflow;
    logic [WIDTH-1:0] abs1;
    logic [WIDTH-1:0] abs2;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] q_fixed;
    logic [WIDTH-1:0] r_fixed;

    assign op_in       = div_op_t'(bus.divOpcode_in);
    assign accept      = bus.start_in && (state == IDLE || state == DONE);
    assign is_signed   = (op_in == DIV_OP) || (op_in == REM_OP);
    assign sign1       = is_signed & bus.operand1_in[WIDTH-1];
    assign sign2       = is_signed & bus.operand2_in[WIDTH-1];
    assign abs1        = sign1 ? -bus.operand1_in : bus.operand1_in;
    assign abs2        = sign2 ? -bus.operand2_in : bus.operand2_in;
    assign div_by_zero = (bus.operand2_in == '0);
    assign overflow    = is_signed && (bus.operand1_in == MOST_NEG) && (bus.operand2_in == '1);

`ifdef ALU_DIVIDER_EARLY_OUT_EN
    logic early_out;
    assign early_out = (abs1 < abs2);
`endif

    alu_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .dvd_bit  (dvd[WIDTH-1]),
        .divisor  (dsr),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    assign q_fixed = q_sign ? -dvd : dvd;
    assign r_fixed = r_sign ? -rem : rem;

    // dvd doubles as the quotient register: dividend bits leave at the top
    // while quotient bits enter at the bottom, one per CALC cycle.
    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state  <= IDLE;
            op     <= DIVU_OP;
            dvd    <= '0;
            dsr    <= '0;
            rem    <= '0;
            result <= '0;
            q_sign <= 1'b0;
            r_sign <= 1'b0;
            count  <= '0;
        end else if (accept) begin
            op     <= op_in;
            dvd    <= abs1;
            dsr    <= abs2;
            rem    <= '0;
            q_sign <= sign1 ^ sign2;
            r_sign <= sign1;
            count  <= '0;
            if (div_by_zero) begin
                result <= (op_in == DIV_OP || op_in == DIVU_OP) ? '1 : bus.operand1_in;
                state  <= DONE;
            end else if (overflow) begin
                result <= (op_in == DIV_OP) ? MOST_NEG : '0;
                state  <= DONE;
            end
`ifdef ALU_DIVIDER_EARLY_OUT_EN
            else if (early_out) begin
                dvd   <= '0;
                rem   <= abs1;
                state <= FIX;
            end
`endif
            else begin
                state <= CALC;
            end
        end else begin
            case (state)
                CALC: begin
                    dvd   <= {dvd[WIDTH-2:0], q_bit};
                    rem   <= rem_next;
                    count <= count + CNT_W'(1);
                    if (count == CNT_W'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result <= (op == DIV_OP || op == DIVU_OP) ? q_fixed : r_fixed;
                    state  <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy_out     = (state == CALC) || (state == FIX);
    assign bus.done_out     = (state == DONE);
    assign bus.result_out   = result;
    assign bus.zeroFlag_out = (result == '0);

endmodule

// File: tb/tb_alu_divider.sv
// Directed vector bench for alu_divider: table of operations with
// hand-computed results and latencies, plus handshake and reset sequences.
module tb_alu_divider;
    import alu_pkg::*;

    localparam int W = 64;
    localparam logic [W-1:0] ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [W-1:0] MOST_NEG = 64'h8000_0000_0000_0000;

`ifdef ALU_DIVIDER_EARLY_OUT_EN
    localparam int EARLY_LAT = 2;
`else
    localparam int EARLY_LAT = 66;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    alu_divider_if #(.WIDTH(W)) bus ();

    alu_divider #(.WIDTH(W)) dut (
        .clk_in   (clk),
        .reset_in (reset),
        .bus      (bus)
    );

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        int           lat;
    } vec_t;

    vec_t vecs[12];

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%h expected=0x%h", name, actual, expected);
        end
    endtask

    // Caller positions at a negedge; returns edges from the accept edge
    // (inclusive) until done_out is seen, capped at 200.
    task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output int cycles);
        bus.start_in     = 1'b1;
        bus.divOpcode_in = op;
        bus.operand1_in  = a;
        bus.operand2_in  = b;
        @(posedge clk);
        #1 bus.start_in = 1'b0;
        cycles = 1;
        @(negedge clk);
        while (!bus.done_out && cycles < 200) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc;
        int pulses;
        int first_done;

        vecs[0]  = '{"divu_100_7",  2'b01, 64'd100, 64'd7, 64'd14, 66};
        vecs[1]  = '{"remu_100_7",  2'b11, 64'd100, 64'd7, 64'd2, 66};
        vecs[2]  = '{"div_20_m3",   2'b00, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA, 66};
        vecs[3]  = '{"rem_20_m3",   2'b10, 64'd20, 64'hFFFF_FFFF_FFFF_FFFD, 64'd2, 66};
        vecs[4]  = '{"rem_m20_3",   2'b10, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 66};
        vecs[5]  = '{"div_m7_2",    2'b00, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 66};
        vecs[6]  = '{"rem_m7_2",    2'b10, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ALL_ONES, 66};
        vecs[7]  = '{"divu_max_2",  2'b01, ALL_ONES, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 66};
        vecs[8]  = '{"divu_5_0",    2'b01, 64'd5, 64'd0, ALL_ONES, 1};
        vecs[9]  = '{"rem_5_0",     2'b10, 64'd5, 64'd0, 64'd5, 1};
        vecs[10] = '{"div_ovf",     2'b00, MOST_NEG, ALL_ONES, MOST_NEG, 1};
        vecs[11] = '{"rem_ovf",     2'b10, MOST_NEG, ALL_ONES, 64'd0, 1};

        bus.start_in     = 1'b0;
        bus.divOpcode_in = 2'b00;
        bus.operand1_in  = '0;
        bus.operand2_in  = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_result", bus.result_out, '0);
        checkOutput("reset_zflag", W'(bus.zeroFlag_out), W'(1));
        checkOutput("reset_busy", W'(bus.busy_out), W'(0));
        checkOutput("reset_done", W'(bus.done_out), W'(0));
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, cyc);
            checkOutput({vecs[i].name, "_latency"}, W'(cyc), W'(vecs[i].lat));
            checkOutput({vecs[i].name, "_result"}, bus.result_out, vecs[i].exp);
            checkOutput({vecs[i].name, "_zflag"}, W'(bus.zeroFlag_out), W'(vecs[i].exp == '0));
            @(negedge clk);
            checkOutput({vecs[i].name, "_done_pulse"}, W'(bus.done_out), W'(0));
            checkOutput({vecs[i].name, "_hold"}, bus.result_out, vecs[i].exp);
        end

        // Small-over-large cases: early-out path when enabled, full latency otherwise
        @(negedge clk);
        applyStimulus(2'b01, 64'd3, 64'd9, cyc);
        checkOutput("divu_3_9_latency", W'(cyc), W'(EARLY_LAT));
        checkOutput("divu_3_9_result", bus.result_out, '0);
        @(negedge clk);
        applyStimulus(2'b10, 64'd5, 64'hFFFF_FFFF_FFFF_FFF7, cyc);
        checkOutput("rem_5_m9_latency", W'(cyc), W'(EARLY_LAT));
        checkOutput("rem_5_m9_result", bus.result_out, 64'd5);

        // start pulsed during CALC must be ignored
        @(negedge clk);
        bus.start_in     = 1'b1;
        bus.divOpcode_in = 2'b01;
        bus.operand1_in  = 64'd100;
        bus.operand2_in  = 64'd7;
        @(posedge clk);
        #1 bus.start_in = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.start_in    = 1'b1;
        bus.operand1_in = 64'd50;
        bus.operand2_in = 64'd5;
        @(posedge clk);
        #1 bus.start_in = 1'b0;
        checkOutput("ignore_busy", W'(bus.busy_out), W'(1));
        pulses     = 0;
        first_done = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.done_out) begin
                pulses++;
                if (first_done < 0) first_done = i;
            end
        end
        checkOutput("ignore_pulses", W'(pulses), W'(1));
        checkOutput("ignore_latency", W'(first_done), W'(55));
        checkOutput("ignore_result", bus.result_out, 64'd14);

        // start held through DONE launches a second operation immediately
        @(negedge clk);
        applyStimulus(2'b01, 64'd100, 64'd7, cyc);
        checkOutput("b2b_first_latency", W'(cyc), W'(66));
        checkOutput("b2b_first_result", bus.result_out, 64'd14);
        applyStimulus(2'b11, 64'd100, 64'd7, cyc);
        checkOutput("b2b_second_latency", W'(cyc), W'(66));
        checkOutput("b2b_second_result", bus.result_out, 64'd2);

        // reset in mid-CALC aborts with no done pulse
        @(negedge clk);
        bus.start_in     = 1'b1;
        bus.divOpcode_in = 2'b01;
        bus.operand1_in  = 64'd100;
        bus.operand2_in  = 64'd7;
        @(posedge clk);
        #1 bus.start_in = 1'b0;
        repeat (29) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", W'(bus.busy_out), W'(0));
        checkOutput("abort_result", bus.result_out, '0);
        checkOutput("abort_zflag", W'(bus.zeroFlag_out), W'(1));
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (bus.done_out) pulses++;
        end
        checkOutput("abort_no_done", W'(pulses), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
